// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared widths, encodings and bus layouts for the EX stage
//               of the 5-stage MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    // Bus widths
    localparam int c_id_to_ex_wd  = 165;
    localparam int c_ex_to_mem_wd = 76;
    localparam int c_ex_to_rf_wd  = 38;
    localparam int c_stall_bus_wd = 6;

    // Stall vector levels
    localparam logic c_stop    = 1'b1;
    localparam logic c_no_stop = 1'b0;

    // Memory access size codes carried in data_ram_wen
    localparam logic [3:0] c_size_word = 4'b1111;
    localparam logic [3:0] c_size_half = 4'b0011;
    localparam logic [3:0] c_size_byte = 4'b0001;

    // One-hot alu_op bit indices
    localparam int c_alu_add  = 11;
    localparam int c_alu_sub  = 10;
    localparam int c_alu_slt  = 9;
    localparam int c_alu_sltu = 8;
    localparam int c_alu_and  = 7;
    localparam int c_alu_nor  = 6;
    localparam int c_alu_or   = 5;
    localparam int c_alu_xor  = 4;
    localparam int c_alu_sll  = 3;
    localparam int c_alu_srl  = 2;
    localparam int c_alu_sra  = 1;
    localparam int c_alu_lui  = 0;

    // One-hot operand select bit indices
    localparam int c_src1_rf    = 0;
    localparam int c_src1_pc    = 1;
    localparam int c_src1_sa    = 2;
    localparam int c_src2_rf    = 0;
    localparam int c_src2_simm  = 1;
    localparam int c_src2_eight = 2;
    localparam int c_src2_zimm  = 3;

    // Divide operation encodings
    localparam logic [1:0] c_div_none = 2'b00;
    localparam logic [1:0] c_div_s    = 2'b01;
    localparam logic [1:0] c_div_u    = 2'b10;

    // One-hot hilo_op bit indices
    localparam int c_hilo_mfhi = 3;
    localparam int c_hilo_mflo = 2;
    localparam int c_hilo_mthi = 1;
    localparam int c_hilo_mtlo = 0;

    // ID -> EX bus, MSB first
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [1:0]  div_op;
        logic [3:0]  hilo_op;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    // Divider control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // Magnitude of a 32-bit operand when treated as signed
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Radix-2 restoring divider, one quotient bit per cycle,
//               with signed fix-up and a DONE state held until released.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic        i_release,
    output logic        o_busy,
    output logic        o_ready,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    localparam logic [4:0] c_last_iter = 5'(DIV_ITERS - 1);

    div_state_t  r_state;
    div_state_t  w_next_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next state: DONE waits for the pipeline to accept the result so a
    // held divide instruction is never started a second time
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start)               w_next_state = S_CALC;
            S_CALC:  if (r_cnt == c_last_iter)  w_next_state = S_DONE;
            S_DONE:  if (i_release)             w_next_state = S_IDLE;
            default:                            w_next_state = S_IDLE;
        endcase
    end

    // Partial remainder shifted left with the next dividend bit
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    // Datapath: latch magnitudes on start, then shift-subtract each CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 5'd0;
            r_quo     <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_cnt     <= 5'd0;
            r_quo     <= abs32(i_op1, i_signed);
            r_rem     <= 32'd0;
            r_divisor <= abs32(i_op2, i_signed);
            // Divide by zero keeps the all-ones quotient unsigned
            r_neg_q   <= i_signed && (i_op1[31] ^ i_op2[31]) && (i_op2 != 32'd0);
            r_neg_r   <= i_signed && i_op1[31];
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 5'd1;
            if (!w_diff[32]) begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
        end
    end

    assign o_busy      = (r_state == S_CALC) || (r_state == S_IDLE && i_start);
    assign o_ready     = (r_state == S_DONE);
    assign o_quotient  = r_neg_q ? (~r_quo + 32'd1) : r_quo;
    assign o_remainder = r_neg_r ? (~r_rem + 32'd1) : r_rem;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : MIPS execute stage - ID/EX register, ALU, store lane
//               steering, HI/LO registers and multicycle divider.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [c_stall_bus_wd-1:0] stall,
    input  logic [c_id_to_ex_wd-1:0]  id_to_ex_bus,
    output logic [c_ex_to_mem_wd-1:0] ex_to_mem_bus,
    output logic [c_ex_to_rf_wd-1:0]  ex_to_rf_bus,
    output logic                      stallreq_for_ex,
    output logic                      data_sram_en,
    output logic [3:0]                data_sram_wen,
    output logic [31:0]               data_sram_addr,
    output logic [31:0]               data_sram_wdata
);

    id_to_ex_t   r_id_to_ex_bus;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_alu_res;
    logic [31:0] w_ex_result;
    logic [15:0] w_imm;
    logic        w_advance;
    logic        w_div_ready;
    logic [31:0] w_div_quo;
    logic [31:0] w_div_rem;
    logic        w_unused;

    assign w_imm     = r_id_to_ex_bus.inst[15:0];
    assign w_advance = (stall[3] == c_no_stop);
    assign w_unused  = ^{stall[5:4], stall[1:0], r_id_to_ex_bus.inst[31:16]};

    // ID/EX register: bubble when ID stalls but EX moves on, hold when both stall
    always_ff @(posedge clk) begin
        if (rst)
            r_id_to_ex_bus <= '0;
        else if (stall[2] == c_stop && stall[3] == c_no_stop)
            r_id_to_ex_bus <= '0;
        else if (stall[2] == c_no_stop)
            r_id_to_ex_bus <= id_to_ex_t'(id_to_ex_bus);
    end

    // Operand selection
    always_comb begin
        w_src1 = r_id_to_ex_bus.rdata1;
        if (r_id_to_ex_bus.sel_alu_src1[c_src1_pc]) w_src1 = r_id_to_ex_bus.pc;
        if (r_id_to_ex_bus.sel_alu_src1[c_src1_sa]) w_src1 = {27'd0, r_id_to_ex_bus.inst[10:6]};
        w_src2 = r_id_to_ex_bus.rdata2;
        if (r_id_to_ex_bus.sel_alu_src2[c_src2_simm])  w_src2 = {{16{w_imm[15]}}, w_imm};
        if (r_id_to_ex_bus.sel_alu_src2[c_src2_zimm])  w_src2 = {16'd0, w_imm};
        if (r_id_to_ex_bus.sel_alu_src2[c_src2_eight]) w_src2 = 32'd8;
    end

    // One-hot ALU; add/sub wrap without overflow detection
    always_comb begin
        w_alu_res = 32'd0;
        if (r_id_to_ex_bus.alu_op[c_alu_add])  w_alu_res |= w_src1 + w_src2;
        if (r_id_to_ex_bus.alu_op[c_alu_sub])  w_alu_res |= w_src1 - w_src2;
        if (r_id_to_ex_bus.alu_op[c_alu_slt])  w_alu_res |= {31'd0, $signed(w_src1) < $signed(w_src2)};
        if (r_id_to_ex_bus.alu_op[c_alu_sltu]) w_alu_res |= {31'd0, w_src1 < w_src2};
        if (r_id_to_ex_bus.alu_op[c_alu_and])  w_alu_res |= w_src1 & w_src2;
        if (r_id_to_ex_bus.alu_op[c_alu_nor])  w_alu_res |= ~(w_src1 | w_src2);
        if (r_id_to_ex_bus.alu_op[c_alu_or])   w_alu_res |= w_src1 | w_src2;
        if (r_id_to_ex_bus.alu_op[c_alu_xor])  w_alu_res |= w_src1 ^ w_src2;
        if (r_id_to_ex_bus.alu_op[c_alu_sll])  w_alu_res |= w_src2 << w_src1[4:0];
        if (r_id_to_ex_bus.alu_op[c_alu_srl])  w_alu_res |= w_src2 >> w_src1[4:0];
        if (r_id_to_ex_bus.alu_op[c_alu_sra])  w_alu_res |= 32'($signed(w_src2) >>> w_src1[4:0]);
        if (r_id_to_ex_bus.alu_op[c_alu_lui])  w_alu_res |= {w_src2[15:0], 16'd0};
    end

    // Result mux: HI/LO moves override the ALU
    always_comb begin
        w_ex_result = w_alu_res;
        if (r_id_to_ex_bus.hilo_op[c_hilo_mfhi]) w_ex_result = r_hi;
        if (r_id_to_ex_bus.hilo_op[c_hilo_mflo]) w_ex_result = r_lo;
    end

    assign data_sram_en   = r_id_to_ex_bus.data_ram_en;
    assign data_sram_addr = r_id_to_ex_bus.rdata1 + {{16{w_imm[15]}}, w_imm};

    // Store lane steering; misaligned accesses simply write no lanes
    always_comb begin
        data_sram_wen   = 4'b0000;
        data_sram_wdata = 32'd0;
        if (r_id_to_ex_bus.data_ram_en) begin
            case (r_id_to_ex_bus.data_ram_wen)
                c_size_word: begin
                    data_sram_wdata = r_id_to_ex_bus.rdata2;
                    if (data_sram_addr[1:0] == 2'b00) data_sram_wen = 4'b1111;
                end
                c_size_half: begin
                    data_sram_wdata = {2{r_id_to_ex_bus.rdata2[15:0]}};
                    if (!data_sram_addr[0]) data_sram_wen = data_sram_addr[1] ? 4'b1100 : 4'b0011;
                end
                c_size_byte: begin
                    data_sram_wdata = {4{r_id_to_ex_bus.rdata2[7:0]}};
                    data_sram_wen   = 4'b0001 << data_sram_addr[1:0];
                end
                default: ;
            endcase
        end
    end

    div_iter #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (r_id_to_ex_bus.div_op != c_div_none),
        .i_signed    (r_id_to_ex_bus.div_op == c_div_s),
        .i_op1       (r_id_to_ex_bus.rdata1),
        .i_op2       (r_id_to_ex_bus.rdata2),
        .i_release   (w_advance),
        .o_busy      (stallreq_for_ex),
        .o_ready     (w_div_ready),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // HI/LO update only on edges where the instruction leaves EX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_advance) begin
            if (w_div_ready) begin
                r_hi <= w_div_rem;
                r_lo <= w_div_quo;
            end else begin
                if (r_id_to_ex_bus.hilo_op[c_hilo_mthi]) r_hi <= r_id_to_ex_bus.rdata1;
                if (r_id_to_ex_bus.hilo_op[c_hilo_mtlo]) r_lo <= r_id_to_ex_bus.rdata1;
            end
        end
    end

    assign ex_to_mem_bus = {r_id_to_ex_bus.pc, r_id_to_ex_bus.data_ram_en,
                            r_id_to_ex_bus.data_ram_wen, r_id_to_ex_bus.sel_rf_res,
                            r_id_to_ex_bus.rf_we, r_id_to_ex_bus.rf_waddr, w_ex_result};
    assign ex_to_rf_bus  = {r_id_to_ex_bus.rf_we, r_id_to_ex_bus.rf_waddr, w_ex_result};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Directed self-checking bench for ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam logic [11:0] OP_ADD  = 12'b1 << c_alu_add;
    localparam logic [11:0] OP_SUB  = 12'b1 << c_alu_sub;
    localparam logic [11:0] OP_SLT  = 12'b1 << c_alu_slt;
    localparam logic [11:0] OP_SLTU = 12'b1 << c_alu_sltu;
    localparam logic [11:0] OP_NOR  = 12'b1 << c_alu_nor;
    localparam logic [11:0] OP_OR   = 12'b1 << c_alu_or;
    localparam logic [11:0] OP_SLL  = 12'b1 << c_alu_sll;
    localparam logic [11:0] OP_SRA  = 12'b1 << c_alu_sra;
    localparam logic [11:0] OP_LUI  = 12'b1 << c_alu_lui;
    localparam logic [2:0]  S1_RF   = 3'b001;
    localparam logic [2:0]  S1_PC   = 3'b010;
    localparam logic [2:0]  S1_SA   = 3'b100;
    localparam logic [3:0]  S2_RF   = 4'b0001;
    localparam logic [3:0]  S2_SIMM = 4'b0010;
    localparam logic [3:0]  S2_8    = 4'b0100;
    localparam logic [3:0]  S2_ZIMM = 4'b1000;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   tb_stall;
    logic [5:0]   stall;
    id_to_ex_t    id_bus;
    logic [164:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         stallreq_for_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [31:0]  ex_result;

    int errors = 0;
    int checks = 0;

    // Stand-in for CTRL: a divide busy request stops IF..EX
    assign stall        = tb_stall | {2'b00, {4{stallreq_for_ex}}};
    assign id_to_ex_bus = id_bus;
    assign ex_result    = ex_to_rf_bus[31:0];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .stallreq_for_ex (stallreq_for_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic id_to_ex_t mk_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        id_to_ex_t t = '0;
        t.div_op = op;
        t.rdata1 = a;
        t.rdata2 = b;
        return t;
    endfunction

    function automatic id_to_ex_t mk_mf(input int idx);
        id_to_ex_t t = '0;
        t.hilo_op[idx] = 1'b1;
        t.rf_we        = 1'b1;
        t.rf_waddr     = 5'd2;
        return t;
    endfunction

    // Issue a divide followed by nxt; return the number of stallreq cycles,
    // ending on the negedge where stallreq is first seen low
    task automatic run_div(input id_to_ex_t dv, input id_to_ex_t nxt, output int n);
        @(negedge clk);
        id_bus = dv;
        @(negedge clk);
        id_bus = nxt;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!stallreq_for_ex) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        id_to_ex_t b = '0;
        b.alu_op = OP_ADD; b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_RF;
        b.rdata1 = 32'h1234; b.data_ram_en = 1'b1; b.rf_we = 1'b1; b.div_op = c_div_s;
        rst = 1'b1; tb_stall = 6'd0; id_bus = b;
        step(); step();
        checks++; if (ex_to_mem_bus !== 76'd0) begin errors++; $display("FAIL reset_mem_bus: got %h expected 0", ex_to_mem_bus); end
        checks++; if (ex_to_rf_bus !== 38'd0) begin errors++; $display("FAIL reset_rf_bus: got %h expected 0", ex_to_rf_bus); end
        checks++; if (stallreq_for_ex !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b expected 0", stallreq_for_ex); end
        checks++; if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== 69'd0) begin
            errors++; $display("FAIL reset_sram: got en=%b wen=%b addr=%h wdata=%h expected all 0",
                               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata); end
        checks++; if ({dut.r_hi, dut.r_lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {dut.r_hi, dut.r_lo}); end
        id_bus = '0;
        rst = 1'b0;
        step();
        checks++; if (ex_to_mem_bus !== 76'd0 || stallreq_for_ex !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got mem=%h stallreq=%b expected 0", ex_to_mem_bus, stallreq_for_ex); end
    endtask

    task automatic test_stall();
        id_to_ex_t b = '0;
        logic [75:0] exp_mem = {32'hBFC0_0010, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd5, 32'h8000_0000};
        b.pc = 32'hBFC0_0010; b.inst = 32'h2485_0001;
        b.alu_op = OP_ADD; b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_SIMM;
        b.rf_we = 1'b1; b.rf_waddr = 5'd5; b.rdata1 = 32'h7FFF_FFFF;
        id_bus = b; tb_stall = 6'd0;
        step();
        checks++; if (ex_result !== 32'h8000_0000) begin errors++; $display("FAIL addiu_wrap: got %h expected 80000000", ex_result); end
        checks++; if (ex_to_mem_bus !== exp_mem) begin errors++; $display("FAIL addiu_mem_bus: got %h expected %h", ex_to_mem_bus, exp_mem); end
        tb_stall = 6'b000100;
        step();
        checks++; if (ex_to_mem_bus !== 76'd0 || ex_to_rf_bus !== 38'd0) begin
            errors++; $display("FAIL bubble: got mem=%h rf=%h expected 0", ex_to_mem_bus, ex_to_rf_bus); end
        tb_stall = 6'd0;
        step();
        b.rdata1 = 32'd1; b.rf_waddr = 5'd9;
        id_bus = b; tb_stall = 6'b001100;
        step();
        checks++; if (ex_to_mem_bus !== exp_mem) begin errors++; $display("FAIL hold: got %h expected %h", ex_to_mem_bus, exp_mem); end
        tb_stall = 6'd0;
        step();
        checks++; if (ex_result !== 32'd2) begin errors++; $display("FAIL after_hold: got %h expected 00000002", ex_result); end
    endtask

    task automatic test_alu();
        id_to_ex_t   b;
        logic [31:0] exp;
        for (int k = 0; k < 9; k++) begin
            b = '0; b.rf_we = 1'b1; b.rf_waddr = 5'd3; exp = 32'd0;
            case (k)
                0: begin b.alu_op = OP_SUB;  b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_RF;
                         b.rdata1 = 32'd5; b.rdata2 = 32'd7; exp = 32'hFFFF_FFFE; end
                1: begin b.alu_op = OP_SLT;  b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_RF;
                         b.rdata1 = 32'hFFFF_FFFF; b.rdata2 = 32'd1; exp = 32'd1; end
                2: begin b.alu_op = OP_SLTU; b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_RF;
                         b.rdata1 = 32'hFFFF_FFFF; b.rdata2 = 32'd1; exp = 32'd0; end
                3: begin b.alu_op = OP_NOR;  b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_RF;
                         b.rdata1 = 32'hF0F0_F0F0; b.rdata2 = 32'h0F0F_0000; exp = 32'h0000_0F0F; end
                4: begin b.alu_op = OP_SLL;  b.sel_alu_src1 = S1_SA; b.sel_alu_src2 = S2_RF;
                         b.inst = 32'h0000_0100; b.rdata2 = 32'd1; exp = 32'h0000_0010; end
                5: begin b.alu_op = OP_SRA;  b.sel_alu_src1 = S1_SA; b.sel_alu_src2 = S2_RF;
                         b.inst = 32'h0000_0100; b.rdata2 = 32'h8000_0000; exp = 32'hF800_0000; end
                6: begin b.alu_op = OP_LUI;  b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_ZIMM;
                         b.inst = 32'h3C01_1234; exp = 32'h1234_0000; end
                7: begin b.alu_op = OP_ADD;  b.sel_alu_src1 = S1_PC; b.sel_alu_src2 = S2_8;
                         b.pc = 32'hBFC0_0100; exp = 32'hBFC0_0108; end
                default: begin b.alu_op = OP_OR; b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_ZIMM;
                         b.inst = 32'h3421_8001; b.rdata1 = 32'h0001_0000; exp = 32'h0001_8001; end
            endcase
            id_bus = b;
            step();
            checks++; if (ex_result !== exp) begin errors++; $display("FAIL alu[%0d]: got %h expected %h", k, ex_result, exp); end
        end
    endtask

    task automatic test_store();
        id_to_ex_t   b;
        logic [3:0]  exp_wen;
        logic [31:0] exp_addr, exp_wdata;
        logic        chk_wdata;
        for (int k = 0; k < 6; k++) begin
            b = '0; b.alu_op = OP_ADD; b.sel_alu_src1 = S1_RF; b.sel_alu_src2 = S2_SIMM;
            b.data_ram_en = 1'b1; chk_wdata = 1'b1;
            case (k)
                0: begin b.data_ram_wen = c_size_byte; b.rdata1 = 32'h1000; b.inst = 32'h0000_0003; b.rdata2 = 32'hAB;
                         exp_addr = 32'h1003; exp_wen = 4'b1000; exp_wdata = 32'hABAB_ABAB; end
                1: begin b.data_ram_wen = c_size_half; b.rdata1 = 32'h1000; b.inst = 32'h0000_0001; b.rdata2 = 32'hBEEF;
                         exp_addr = 32'h1001; exp_wen = 4'b0000; exp_wdata = 32'd0; chk_wdata = 1'b0; end
                2: begin b.data_ram_wen = c_size_half; b.rdata1 = 32'h1000; b.inst = 32'h0000_0002; b.rdata2 = 32'h1234_BEEF;
                         exp_addr = 32'h1002; exp_wen = 4'b1100; exp_wdata = 32'hBEEF_BEEF; end
                3: begin b.data_ram_wen = c_size_word; b.rdata1 = 32'h2000; b.inst = 32'h0000_FFFC; b.rdata2 = 32'hDEAD_BEEF;
                         exp_addr = 32'h1FFC; exp_wen = 4'b1111; exp_wdata = 32'hDEAD_BEEF; end
                4: begin b.data_ram_wen = c_size_word; b.rdata1 = 32'h2000; b.inst = 32'h0000_0002; b.rdata2 = 32'h5555_5555;
                         exp_addr = 32'h2002; exp_wen = 4'b0000; exp_wdata = 32'd0; chk_wdata = 1'b0; end
                default: begin b.data_ram_wen = 4'b0000; b.rdata1 = 32'h3000; b.inst = 32'h0000_0004;
                         exp_addr = 32'h3004; exp_wen = 4'b0000; exp_wdata = 32'd0; chk_wdata = 1'b0; end
            endcase
            id_bus = b;
            step();
            checks++; if (data_sram_en !== 1'b1 || data_sram_wen !== exp_wen || data_sram_addr !== exp_addr) begin
                errors++; $display("FAIL mem[%0d]: got en=%b wen=%b addr=%h expected en=1 wen=%b addr=%h",
                                   k, data_sram_en, data_sram_wen, data_sram_addr, exp_wen, exp_addr); end
            checks++; if (ex_result !== exp_addr || ex_to_mem_bus[42:39] !== b.data_ram_wen) begin
                errors++; $display("FAIL mem_bus[%0d]: got result=%h size=%b expected result=%h size=%b",
                                   k, ex_result, ex_to_mem_bus[42:39], exp_addr, b.data_ram_wen); end
            if (chk_wdata) begin
                checks++; if (data_sram_wdata !== exp_wdata) begin
                    errors++; $display("FAIL wdata[%0d]: got %h expected %h", k, data_sram_wdata, exp_wdata); end
            end
        end
        id_bus = '0;
        step();
    endtask

    task automatic test_div_signed();
        int n;
        run_div(mk_div(c_div_s, 32'hFFFF_FFF9, 32'd2), mk_mf(c_hilo_mflo), n);
        checks++; if (n !== 33) begin errors++; $display("FAIL div_stall_cycles: got %0d expected 33", n); end
        step();
        checks++; if (dut.r_lo !== 32'hFFFF_FFFD || dut.r_hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_hilo: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", dut.r_hi, dut.r_lo); end
        checks++; if (ex_result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_mflo: got %h expected fffffffd", ex_result); end
        id_bus = mk_mf(c_hilo_mfhi);
        step();
        checks++; if (ex_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_mfhi: got %h expected ffffffff", ex_result); end
        id_bus = '0;
        step();
    endtask

    task automatic test_divu_zero();
        int n;
        run_div(mk_div(c_div_u, 32'hFFFF_FFFF, 32'd0), mk_mf(c_hilo_mflo), n);
        checks++; if (n !== 33) begin errors++; $display("FAIL divu0_stall_cycles: got %0d expected 33", n); end
        step();
        checks++; if (ex_result !== 32'hFFFF_FFFF || dut.r_hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divu0_result: got lo=%h hi=%h expected ffffffff ffffffff", ex_result, dut.r_hi); end
        id_bus = '0;
        step();
    endtask

    task automatic test_hold_done();
        int n;
        run_div(mk_div(c_div_s, 32'd100, 32'd7), mk_mf(c_hilo_mflo), n);
        tb_stall = 6'b001111;
        checks++; if (n !== 33) begin errors++; $display("FAIL hold_stall_cycles: got %0d expected 33", n); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (stallreq_for_ex !== 1'b0) begin errors++; $display("FAIL hold_restart[%0d]: got %b expected 0", i, stallreq_for_ex); end
        end
        checks++; if (dut.r_lo !== 32'hFFFF_FFFF || dut.u_div.r_state !== S_DONE) begin
            errors++; $display("FAIL hold_no_write: got lo=%h state=%0d expected lo=ffffffff state=2", dut.r_lo, dut.u_div.r_state); end
        tb_stall = 6'd0;
        step();
        checks++; if (ex_result !== 32'd14 || dut.r_hi !== 32'd2) begin
            errors++; $display("FAIL hold_release: got lo=%h hi=%h expected 0000000e 00000002", ex_result, dut.r_hi); end
        id_bus = '0;
        step();
        checks++; if (stallreq_for_ex !== 1'b0 || dut.r_lo !== 32'd14) begin
            errors++; $display("FAIL hold_once: got stallreq=%b lo=%h expected 0 0000000e", stallreq_for_ex, dut.r_lo); end
    endtask

    task automatic test_reset_mid_div();
        int n;
        @(negedge clk);
        id_bus = mk_div(c_div_s, 32'd50, 32'd5);
        @(negedge clk);
        id_bus = '0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (stallreq_for_ex) n++;
            @(negedge clk);
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL mid_busy: got %0d expected 10", n); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (stallreq_for_ex !== 1'b0 || dut.u_div.r_state !== S_IDLE) begin
            errors++; $display("FAIL mid_rst_fsm: got stallreq=%b state=%0d expected 0 0", stallreq_for_ex, dut.u_div.r_state); end
        checks++; if (dut.r_hi !== 32'd0 || dut.r_lo !== 32'd0) begin
            errors++; $display("FAIL mid_rst_hilo: got hi=%h lo=%h expected 0 0", dut.r_hi, dut.r_lo); end
        run_div(mk_div(c_div_s, 32'd50, 32'd5), mk_mf(c_hilo_mflo), n);
        checks++; if (n !== 33) begin errors++; $display("FAIL mid_rerun_cycles: got %0d expected 33", n); end
        step();
        checks++; if (ex_result !== 32'd10) begin errors++; $display("FAIL mid_rerun_lo: got %h expected 0000000a", ex_result); end
        id_bus = mk_mf(c_hilo_mfhi);
        step();
        checks++; if (ex_result !== 32'd0) begin errors++; $display("FAIL mid_rerun_hi: got %h expected 00000000", ex_result); end
        id_bus = '0;
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tb_stall = 6'd0;
        id_bus = '0;
        @(negedge clk);
        test_reset();
        test_stall();
        test_alu();
        test_store();
        test_div_signed();
        test_divu_zero();
        test_hold_done();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
